// File: rtl/rng_xs.sv
// Xorshift PRNG with req/ack port, runtime reseed and post-seed warm-up.
// Define RNG_ENTROPY_EN to add the entropy_in port that is mixed into bit 0.
module rng_xs #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h04),
   parameter int               SHIFT_A = 1,
   parameter int               SHIFT_B = 1,
   parameter int               SHIFT_C = 2,
   parameter int               WARMUP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_val,
   input  logic             req,
   input  logic [WIDTH-1:0] req_mask,
`ifdef RNG_ENTROPY_EN
   input  logic             entropy_in,
`endif
   output logic             ack,
   output logic [WIDTH-1:0] rnd,
   output logic             busy,
   output logic             req_drop
);

   typedef enum logic {PH_WARM, PH_RUN} phase_e;

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? ONE : SEED;
   localparam logic [7:0]       WARM_INIT = 8'(WARMUP);
   localparam phase_e           PH_INIT   = (WARMUP > 0) ? PH_WARM : PH_RUN;

   logic [WIDTH-1:0] state_q, state_d, state_adv;
   logic [7:0]       warm_cnt_q, warm_cnt_d;
   phase_e           phase_q, phase_d;
   logic             pending_q, pending_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] rnd_q, rnd_d;
   logic             drop_q, drop_d;

   function automatic logic [WIDTH-1:0] xs_next(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] t;
      t = x ^ (x << SHIFT_A);
      t = t ^ (t >> SHIFT_B);
      t = t ^ (t << SHIFT_C);
      return t;
   endfunction

   always_comb begin
      state_adv = xs_next(state_q);
`ifdef RNG_ENTROPY_EN
      state_adv = state_adv ^ {{(WIDTH-1){1'b0}}, entropy_in};
      if (state_adv == '0) state_adv = ONE;
`endif
   end

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      phase_d    = phase_q;
      pending_d  = pending_q;
      mask_d     = mask_q;
      ack_d      = 1'b0;
      rnd_d      = rnd_q;
      drop_d     = 1'b0;

      if (seed_load) begin
         state_d    = (seed_val == '0) ? ONE : seed_val;
         warm_cnt_d = WARM_INIT;
         phase_d    = PH_INIT;
      end else begin
         state_d = state_adv;
      end

      // A reseed edge handles requests as if still warming up, so a pending
      // request survives the reseed and waits for the new warm-up.
      if (seed_load || phase_q == PH_WARM) begin
         if (!seed_load) begin
            warm_cnt_d = warm_cnt_q - 8'd1;
            if (warm_cnt_q == 8'd1) phase_d = PH_RUN;
         end
         if (req) begin
            if (pending_q) begin
               drop_d = 1'b1;
            end else begin
               pending_d = 1'b1;
               mask_d    = req_mask;
            end
         end
      end else if (pending_q) begin
         ack_d     = 1'b1;
         rnd_d     = state_q & mask_q;
         pending_d = 1'b0;
         drop_d    = req;
      end else if (req) begin
         ack_d = 1'b1;
         rnd_d = state_q & req_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SEED_INIT;
         warm_cnt_q <= WARM_INIT;
         phase_q    <= PH_INIT;
         pending_q  <= 1'b0;
         mask_q     <= '0;
         ack_q      <= 1'b0;
         rnd_q      <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         phase_q    <= phase_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         ack_q      <= ack_d;
         rnd_q      <= rnd_d;
         drop_q     <= drop_d;
      end
   end

   assign ack      = ack_q;
   assign rnd      = rnd_q;
   assign req_drop = drop_q;
   assign busy     = (phase_q == PH_WARM) || pending_q;

endmodule

// File: tb/tb_rng_xs.sv
// Directed bench for rng_xs: two instances (WARMUP=0 and WARMUP=4), SEED=1,
// expected words hand-computed from the 8-bit xorshift 1/1/2 sequence.
module tb_rng_xs;

   // Sequence from seed 1: 01 0A 55 80 C0 E0 F0 ...
   logic       clk = 1'b0;
   logic       rst;

   logic       seed_load0, seed_load4;
   logic [7:0] seed_val0, seed_val4;
   logic       req0, req4;
   logic [7:0] mask0, mask4;
   logic       ack0, ack4;
   logic [7:0] rnd0, rnd4;
   logic       busy0, busy4;
   logic       drop0, drop4;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         acks;
   int         ack_edge;
   logic [7:0] ack_rnd;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   rng_xs #(.WIDTH(8), .SEED(8'h01), .SHIFT_A(1), .SHIFT_B(1), .SHIFT_C(2), .WARMUP(0)) u_w0 (
      .clk(clk), .rst(rst), .seed_load(seed_load0), .seed_val(seed_val0),
      .req(req0), .req_mask(mask0),
`ifdef RNG_ENTROPY_EN
      .entropy_in(1'b0),
`endif
      .ack(ack0), .rnd(rnd0), .busy(busy0), .req_drop(drop0)
   );

   rng_xs #(.WIDTH(8), .SEED(8'h01), .SHIFT_A(1), .SHIFT_B(1), .SHIFT_C(2), .WARMUP(4)) u_w4 (
      .clk(clk), .rst(rst), .seed_load(seed_load4), .seed_val(seed_val4),
      .req(req4), .req_mask(mask4),
`ifdef RNG_ENTROPY_EN
      .entropy_in(1'b0),
`endif
      .ack(ack4), .rnd(rnd4), .busy(busy4), .req_drop(drop4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      seed_load0 = 1'b0; seed_val0 = 8'h00; req0 = 1'b0; mask0 = 8'h00;
      seed_load4 = 1'b0; seed_val4 = 8'h00; req4 = 1'b0; mask4 = 8'h00;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      chk("rst_ack0", ack0, 0);
      chk("rst_rnd0", rnd0, 8'h00);
      chk("rst_busy0", busy0, 0);
      chk("rst_drop0", drop0, 0);
      chk("rst_busy4", busy4, 1);
      chk("rst_ack4", ack4, 0);
      rst = 1'b0;

      // Back-to-back requests straight after reset release, no warm-up
      exp_q = '{8'h01, 8'h0A, 8'h55};
      req0 = 1'b1; mask0 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk("t1_ack", ack0, 1);
         chk("t1_rnd", rnd0, exp_v);
      end
      req0 = 1'b0;
      tick();
      chk("t1_ack_low", ack0, 0);
      chk("t1_rnd_held", rnd0, 8'h55);
      chk("t1_busy", busy0, 0);

      // Zero seed replaced by 1, then masks applied to the restarted sequence
      seed_load0 = 1'b1; seed_val0 = 8'h00;
      tick();
      seed_load0 = 1'b0;
      chk("t2_seed_ack", ack0, 0);
      req0 = 1'b1; mask0 = 8'hFF;
      tick();
      chk("t2_ack", ack0, 1);
      chk("t2_rnd_zero_sub", rnd0, 8'h01);
      mask0 = 8'hF0;
      tick();
      chk("t2_rnd_mask_f0", rnd0, 8'h00);
      mask0 = 8'h0F;
      tick();
      chk("t2_rnd_mask_0f", rnd0, 8'h05);
      req0 = 1'b0;
      tick();

      // Request during warm-up; served after the RUN transition
      do_reset();
      req4 = 1'b1; mask4 = 8'h0F;
      tick();
      req4 = 1'b0;
      chk("t3_e1_ack", ack4, 0);
      chk("t3_e1_busy", busy4, 1);
      for (int e = 2; e <= 4; e++) begin
         tick();
         chk("t3_warm_ack", ack4, 0);
         chk("t3_warm_busy", busy4, 1);
      end
      req4 = 1'b1; mask4 = 8'hFF;
      tick();
      chk("t3_e5_ack", ack4, 1);
      chk("t3_e5_rnd", rnd4, 8'h00);
      chk("t3_e5_drop", drop4, 1);
      chk("t3_e5_busy", busy4, 0);
      tick();
      chk("t3_e6_ack", ack4, 1);
      chk("t3_e6_rnd", rnd4, 8'hE0);
      chk("t3_e6_drop", drop4, 0);
      req4 = 1'b0;
      tick();
      chk("t3_e7_ack", ack4, 0);
      chk("t3_e7_rnd_held", rnd4, 8'hE0);

      // Two requests in warm-up: second dropped, first mask kept
      do_reset();
      req4 = 1'b1; mask4 = 8'hF0;
      tick();
      chk("t4_e1_drop", drop4, 0);
      mask4 = 8'h0F;
      tick();
      chk("t4_e2_drop", drop4, 1);
      chk("t4_e2_ack", ack4, 0);
      req4 = 1'b0;
      tick();
      chk("t4_e3_drop", drop4, 0);
      acks = 0; ack_edge = 0; ack_rnd = 8'h00;
      for (int e = 4; e <= 9; e++) begin
         tick();
         if (ack4) begin
            acks++; ack_edge = e; ack_rnd = rnd4;
         end
      end
      chk("t4_ack_count", acks, 1);
      chk("t4_ack_edge", ack_edge, 5);
      chk("t4_ack_rnd", ack_rnd, 8'hC0);

      // Reseed at warm_cnt=2 with a request pending
      do_reset();
      req4 = 1'b1; mask4 = 8'hFF;
      tick();
      req4 = 1'b0;
      tick();
      seed_load4 = 1'b1; seed_val4 = 8'h01;
      tick();
      seed_load4 = 1'b0;
      chk("t5_e3_busy", busy4, 1);
      chk("t5_e3_ack", ack4, 0);
      acks = 0; ack_edge = 0; ack_rnd = 8'h00;
      for (int e = 4; e <= 11; e++) begin
         tick();
         if (ack4) begin
            acks++; ack_edge = e; ack_rnd = rnd4;
         end
      end
      chk("t5_ack_count", acks, 1);
      chk("t5_ack_edge", ack_edge, 8);
      chk("t5_ack_rnd", ack_rnd, 8'hC0);
      chk("t5_busy_end", busy4, 0);

      // rst mid-warm-up with a request pending (rnd currently C0)
      seed_load4 = 1'b1; seed_val4 = 8'h5A; req4 = 1'b1; mask4 = 8'hFF;
      tick();
      seed_load4 = 1'b0; req4 = 1'b0;
      chk("t6_busy", busy4, 1);
      chk("t6_ack", ack4, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_ack", ack4, 0);
      chk("t6_rst_rnd", rnd4, 8'h00);
      chk("t6_rst_busy", busy4, 1);
      chk("t6_rst_drop", drop4, 0);
      tick();
      rst = 1'b0;
      acks = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (ack4) acks++;
      end
      chk("t6_no_ack", acks, 0);
      chk("t6_busy_end", busy4, 0);
      chk("t6_rnd_end", rnd4, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
